// File: rtl/fetch_ctrl_pkg.sv
// Shared core definitions: run-state encoding, word width and the IF/ID register layout.
package core_pkg;
    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] HALT_WORD_DEF = 32'h0000_000C;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_FAULT  = 2'd3
    } run_state_e;

    typedef struct packed {
        logic              valid;
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc_plus4;
    } ifid_t;
endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus: instruction memory port, hazard/redirect inputs and IF/ID outputs.
interface fetch_ctrl_if;
    import core_pkg::*;

    logic [WORD_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_rdata;
    logic              stall;
    logic              redirect_valid;
    logic [WORD_W-1:0] redirect_pc;
    logic              ifid_valid;
    logic [WORD_W-1:0] ifid_instr;
    logic [WORD_W-1:0] ifid_pc_plus4;

    modport master (
        output imem_addr, ifid_valid, ifid_instr, ifid_pc_plus4,
        input  imem_rdata, stall, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_addr, ifid_valid, ifid_instr, ifid_pc_plus4,
        output imem_rdata, stall, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_ctrl_pc_check.sv
// Combinational PC sanity check: flags misaligned or out-of-memory byte addresses.
module pc_check
    import core_pkg::*;
#(
    parameter int IMEM_WORDS = 1024
) (
    input  logic [WORD_W-1:0] pc,
    output logic              bad
);
    assign bad = (pc[1:0] != 2'b00) || ((pc >> 2) >= WORD_W'(IMEM_WORDS));
endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, loads IF/ID and runs start/stop control.
//   state  | meaning
//   IDLE   | out of reset, waiting for start
//   RUN    | fetching one word per unstalled cycle
//   HALTED | stopped by halt_req or a syscall word; start resumes at held pc
//   FAULT  | bad pc or redirect target; left only through rst_n
module fetch_ctrl
    import core_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                IMEM_WORDS = 1024,
    parameter logic [WORD_W-1:0] HALT_WORD  = HALT_WORD_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               halt_req,
    fetch_ctrl_if.master       bus,
    output logic [1:0]         state,
    output logic               fault,
    output logic [WORD_W-1:0]  fetch_count
);
    run_state_e        state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    ifid_t             ifid_q, ifid_d;
    logic              fault_q, fault_d;
    logic [WORD_W-1:0] count_q, count_d;
    logic [WORD_W-1:0] pc_plus4;
    logic              pc_bad, tgt_bad;

    pc_check #(.IMEM_WORDS(IMEM_WORDS)) u_chk_pc (
        .pc  (pc_q),
        .bad (pc_bad)
    );

    pc_check #(.IMEM_WORDS(IMEM_WORDS)) u_chk_tgt (
        .pc  (bus.redirect_pc),
        .bad (tgt_bad)
    );

    assign pc_plus4 = pc_q + WORD_W'(4);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ifid_d  = ifid_q;
        fault_d = fault_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                end
            end
            ST_RUN: begin
                if (pc_bad || (bus.redirect_valid && tgt_bad)) begin
                    state_d      = ST_FAULT;
                    fault_d      = 1'b1;
                    ifid_d.valid = 1'b0;
                end else if (halt_req) begin
                    state_d      = ST_HALTED;
                    ifid_d.valid = 1'b0;
                end else if (bus.redirect_valid) begin
                    // Redirect wins over stall: the wrong-path word is flushed as a bubble.
                    pc_d         = bus.redirect_pc;
                    ifid_d.valid = 1'b0;
                end else if (!bus.stall) begin
                    ifid_d  = '{valid: 1'b1, instr: bus.imem_rdata, pc_plus4: pc_plus4};
                    pc_d    = pc_plus4;
                    count_d = count_q + WORD_W'(1);
                    if (bus.imem_rdata == HALT_WORD) state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                ifid_d.valid = 1'b0;
                if (start && !halt_req) state_d = ST_RUN;
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            ifid_q  <= '0;
            fault_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    assign bus.imem_addr     = pc_q;
    assign bus.ifid_valid    = ifid_q.valid;
    assign bus.ifid_instr    = ifid_q.instr;
    assign bus.ifid_pc_plus4 = ifid_q.pc_plus4;
    assign state             = state_q;
    assign fault             = fault_q;
    assign fetch_count       = count_q;
endmodule
